// File: rtl/pipe_control_unit.sv
// MIPS main control for the 5-stage pipeline: ID decode registered into ID/EX, load-use stall, flush bubbles.
// Optional: define PCU_ILLEGAL_TRAP_EN to make unknown opcodes set a sticky illegal flag.
module pipe_control_unit #(
  parameter int ALUOP_W     = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [5:0]             opcode,
  input  logic [4:0]             rs,
  input  logic [4:0]             rt,
  input  logic                   ex_flush,
  output logic                   stall,
  output logic                   ex_valid,
  output logic                   ex_RegDst,
  output logic                   ex_branch,
  output logic                   ex_branch_ne,
  output logic                   ex_Memread,
  output logic                   ex_MemtoReg,
  output logic                   ex_MemWrite,
  output logic                   ex_AluSrc,
  output logic                   ex_RegWrite,
  output logic [ALUOP_W-1:0]     ex_ALUop,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  // dec_ctrl order: RegDst, branch, branch_ne, Memread, MemtoReg, MemWrite, AluSrc, RegWrite
  logic [7:0] dec_ctrl;
  logic [3:0] dec_alu;
  logic       dec_known;
  logic       uses_rt;
  logic [4:0] ex_rt;
  logic       load_use;
  logic       bubble;

  always_comb begin
    dec_ctrl  = 8'b0;
    dec_alu   = 4'b0;
    dec_known = 1'b1;
    uses_rt   = 1'b0;
    case (opcode)
      OP_R:    begin dec_ctrl = 8'b1000_0001; dec_alu = 4'b0010; uses_rt = 1'b1; end
      OP_LW:   begin dec_ctrl = 8'b0001_1011; dec_alu = 4'b0000; end
      OP_SW:   begin dec_ctrl = 8'b0000_0110; dec_alu = 4'b0000; uses_rt = 1'b1; end
      OP_BEQ:  begin dec_ctrl = 8'b0100_0000; dec_alu = 4'b0001; uses_rt = 1'b1; end
      OP_BNE:  begin dec_ctrl = 8'b0110_0000; dec_alu = 4'b0001; uses_rt = 1'b1; end
      OP_ADDI: begin dec_ctrl = 8'b0000_0011; dec_alu = 4'b0000; end
      OP_ANDI: begin dec_ctrl = 8'b0000_0011; dec_alu = 4'b0011; end
      OP_ORI:  begin dec_ctrl = 8'b0000_0011; dec_alu = 4'b0100; end
      OP_SLTI: begin dec_ctrl = 8'b0000_0011; dec_alu = 4'b0101; end
      default: dec_known = 1'b0;
    endcase
  end

  // rt is only a true source for R-type, stores and branches; I-type ALU ops and loads write it
  assign load_use = id_valid & ex_Memread & (ex_rt != 5'd0) &
                    ((ex_rt == rs) | ((ex_rt == rt) & uses_rt));
  assign stall    = ~reset & ~ex_flush & load_use;
  assign bubble   = ex_flush | ~id_valid | stall | ~dec_known;

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      ex_valid     <= 1'b0;
      ex_RegDst    <= 1'b0;
      ex_branch    <= 1'b0;
      ex_branch_ne <= 1'b0;
      ex_Memread   <= 1'b0;
      ex_MemtoReg  <= 1'b0;
      ex_MemWrite  <= 1'b0;
      ex_AluSrc    <= 1'b0;
      ex_RegWrite  <= 1'b0;
      ex_ALUop     <= '0;
      ex_rt        <= 5'd0;
    end else begin
      ex_valid     <= 1'b1;
      {ex_RegDst, ex_branch, ex_branch_ne, ex_Memread,
       ex_MemtoReg, ex_MemWrite, ex_AluSrc, ex_RegWrite} <= dec_ctrl;
      ex_ALUop     <= ALUOP_W'(dec_alu);
      ex_rt        <= rt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

`ifdef PCU_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)
      illegal <= 1'b0;
    else if (id_valid && !ex_flush && !dec_known)
      illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: expected ID/EX bundles are queued at drive time and checked one cycle later.
// A second instance with a 2-bit stall counter exercises saturation.
module tb_pipe_control_unit;

  logic clk = 1'b0;
  logic reset, id_valid, ex_flush;
  logic [5:0] opcode;
  logic [4:0] rs, rt;

  logic stall, ex_valid, ex_RegDst, ex_branch, ex_branch_ne, ex_Memread;
  logic ex_MemtoReg, ex_MemWrite, ex_AluSrc, ex_RegWrite, illegal;
  logic [3:0]  ex_ALUop;
  logic [15:0] stall_cnt;

  logic stall2, ex_valid2, ex_RegDst2, ex_branch2, ex_branch_ne2, ex_Memread2;
  logic ex_MemtoReg2, ex_MemWrite2, ex_AluSrc2, ex_RegWrite2, illegal2;
  logic [3:0] ex_ALUop2;
  logic [1:0] stall_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_control_unit #(.ALUOP_W(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .rs(rs), .rt(rt),
    .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid), .ex_RegDst(ex_RegDst),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_Memread(ex_Memread),
    .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite), .ex_AluSrc(ex_AluSrc),
    .ex_RegWrite(ex_RegWrite), .ex_ALUop(ex_ALUop), .stall_cnt(stall_cnt), .illegal(illegal)
  );

  pipe_control_unit #(.ALUOP_W(4), .STALL_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .rs(rs), .rt(rt),
    .ex_flush(ex_flush), .stall(stall2), .ex_valid(ex_valid2), .ex_RegDst(ex_RegDst2),
    .ex_branch(ex_branch2), .ex_branch_ne(ex_branch_ne2), .ex_Memread(ex_Memread2),
    .ex_MemtoReg(ex_MemtoReg2), .ex_MemWrite(ex_MemWrite2), .ex_AluSrc(ex_AluSrc2),
    .ex_RegWrite(ex_RegWrite2), .ex_ALUop(ex_ALUop2), .stall_cnt(stall_cnt2), .illegal(illegal2)
  );

  typedef struct packed {
    logic [12:0] bundle;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [1:0]  exp_cnt2 = 2'd0;
  logic        exp_ill = 1'b0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, SLTI = 6'b001010, BAD = 6'b111111;

  // {known, RegDst, branch, branch_ne, Memread, MemtoReg, MemWrite, AluSrc, RegWrite, ALUop[3:0]}
  function automatic logic [12:0] model(input logic [5:0] op);
    case (op)
      R:       return 13'b1_10000001_0010;
      LW:      return 13'b1_00011011_0000;
      SW:      return 13'b1_00000110_0000;
      BEQ:     return 13'b1_01000000_0001;
      BNE:     return 13'b1_01100000_0001;
      ADDI:    return 13'b1_00000011_0000;
      ANDI:    return 13'b1_00000011_0011;
      ORI:     return 13'b1_00000011_0100;
      SLTI:    return 13'b1_00000011_0101;
      default: return 13'b0;
    endcase
  endfunction

  task automatic step(input logic r, input logic v, input logic [5:0] op, input logic [4:0] s,
                      input logic [4:0] t, input logic fl, input logic exp_stall, input string tag);
    exp_t e;
    exp_t got;
    logic [12:0] m;
    logic bub;
    @(negedge clk);
    reset = r; id_valid = v; opcode = op; rs = s; rt = t; ex_flush = fl;
    #1;
    checks++;
    assert (stall === exp_stall) else begin
      errors++;
      $error("FAIL %s stall observed=%0b expected=%0b", tag, stall, exp_stall);
    end
    m = model(op);
    e = '0;
    if (r) begin
      exp_cnt = 16'd0; exp_cnt2 = 2'd0; exp_ill = 1'b0;
    end else begin
      bub = fl | !v | exp_stall | !m[12];
      e.bundle = bub ? 13'b0 : {1'b1, m[11:0]};
      if (exp_stall) begin
        if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
        if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
      end
`ifdef PCU_ILLEGAL_TRAP_EN
      if (v && !fl && !m[12]) exp_ill = 1'b1;
`endif
    end
    e.cnt = exp_cnt; e.cnt2 = exp_cnt2; e.ill = exp_ill;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got.bundle = {ex_valid, ex_RegDst, ex_branch, ex_branch_ne, ex_Memread, ex_MemtoReg,
                  ex_MemWrite, ex_AluSrc, ex_RegWrite, ex_ALUop};
    got.cnt = stall_cnt; got.cnt2 = stall_cnt2; got.ill = illegal;
    e = sb.pop_front();
    checks++;
    assert (got.bundle === e.bundle) else begin
      errors++;
      $error("FAIL %s ex_bundle observed=%b expected=%b", tag, got.bundle, e.bundle);
    end
    checks++;
    assert (got.cnt === e.cnt) else begin
      errors++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, got.cnt, e.cnt);
    end
    checks++;
    assert (got.cnt2 === e.cnt2) else begin
      errors++;
      $error("FAIL %s stall_cnt_w2 observed=%0d expected=%0d", tag, got.cnt2, e.cnt2);
    end
    checks++;
    assert (got.ill === e.ill) else begin
      errors++;
      $error("FAIL %s illegal observed=%0b expected=%0b", tag, got.ill, e.ill);
    end
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; opcode = 6'd0; rs = 5'd0; rt = 5'd0; ex_flush = 1'b0;
    step(1, 0, R, 0, 0, 0, 0, "reset0");
    step(1, 1, LW, 1, 5, 0, 0, "reset1");
    // basic R-type decode
    step(0, 1, R, 1, 2, 0, 0, "r_type");
    // load-use on rs: exactly one stall, then the add issues
    step(0, 1, LW, 1, 5, 0, 0, "lw_rt5");
    step(0, 1, R, 5, 6, 0, 1, "add_use_rs");
    step(0, 1, R, 5, 6, 0, 0, "add_issue");
    // rt==0 and I-type rt are not hazards
    step(0, 1, LW, 1, 0, 0, 0, "lw_rt0");
    step(0, 1, R, 0, 0, 0, 0, "add_rs0");
    step(0, 1, LW, 1, 7, 0, 0, "lw_rt7");
    step(0, 1, ADDI, 3, 7, 0, 0, "addi_rt7");
    // store reads rt
    step(0, 1, LW, 1, 7, 0, 0, "lw_rt7b");
    step(0, 1, SW, 1, 7, 0, 1, "sw_use_rt");
    step(0, 1, SW, 1, 7, 0, 0, "sw_issue");
    // flush beats a load-use condition
    step(0, 1, LW, 1, 9, 0, 0, "lw_rt9");
    step(0, 1, BEQ, 9, 2, 1, 0, "flush_vs_hazard");
    step(0, 1, BEQ, 9, 2, 0, 0, "beq_issue");
    // back-to-back loads, then dependent add
    step(0, 1, LW, 1, 4, 0, 0, "lw_a");
    step(0, 1, LW, 2, 4, 0, 0, "lw_b");
    step(0, 1, R, 4, 1, 0, 1, "add_after_lw_lw");
    step(0, 1, R, 4, 1, 0, 0, "add_after_lw_lw_issue");
    // invalid slot never stalls
    step(0, 1, LW, 1, 3, 0, 0, "lw_rt3");
    step(0, 0, R, 3, 3, 0, 0, "invalid_slot");
    // unknown opcode bubbles; trap flag sticks when enabled
    step(0, 1, BAD, 1, 2, 0, 0, "bad_op");
    step(0, 1, ORI, 1, 2, 0, 0, "ori");
    step(0, 1, ANDI, 1, 2, 0, 0, "andi");
    step(0, 1, SLTI, 1, 2, 0, 0, "slti");
    step(0, 1, BNE, 1, 2, 0, 0, "bne");
    step(0, 1, BAD, 1, 2, 1, 0, "bad_op_flushed");
    // more stalls to saturate the 2-bit counter
    for (int i = 0; i < 3; i++) begin
      step(0, 1, LW, 1, 5, 0, 0, "sat_lw");
      step(0, 1, BNE, 2, 5, 0, 1, "sat_bne_use_rt");
      step(0, 1, BNE, 2, 5, 0, 0, "sat_bne_issue");
    end
    // reset in the middle of a stall
    step(0, 1, LW, 1, 5, 0, 0, "pre_reset_lw");
    step(1, 1, R, 5, 6, 0, 0, "reset_mid_stall");
    step(0, 1, R, 5, 6, 0, 0, "post_reset_add");
    step(0, 0, R, 0, 0, 0, 0, "idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
